pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline controller for the RISC-V core. It replaces the single hold/jump combiner.
- Generalised to NUM_STAGES pipeline registers, with per-stage stall and flush vectors.
- Adds multi-cycle jump flush, an interrupt-entry handshake and a hold watchdog.
- Sits between the EX/multi-cycle units, the CSR/interrupt unit, the PC register and the stage registers (if_id, id_ex, ...).

Parameters:
- ADDR_WIDTH, 32, width of jump/interrupt target addresses
- NUM_STAGES, 3, number of controlled pipeline registers; index 0 = PC, 1 = if_id, 2 = id_ex, ...; must be >= 2
- FLUSH_CYCLES, 1, cycles flush stays asserted after a redirect; must be >= 1
- TO_WIDTH, 8, watchdog counter width; timeout value = 2^TO_WIDTH-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  branch/jump taken, from ex
- jump_addr_i  in  ADDR_WIDTH  redirect target, from ex
- hold_req_i  in  NUM_STAGES  bit k: stall registers 0..k
- irq_i  in  1  level interrupt pending, from CSR unit
- int_ack_i  in  1  CSR unit accepted entry; int_addr_i valid
- int_addr_i  in  ADDR_WIDTH  trap vector
- timeout_clr_i  in  1  clears hold_timeout_o
- stall_o  out  NUM_STAGES  freeze register k
- flush_o  out  NUM_STAGES  load bubble into register k (bit 0 always 0)
- jump_en_o  out  1  PC redirect
- jump_addr_o  out  ADDR_WIDTH  PC redirect target
- int_req_o  out  1  request interrupt entry
- hold_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, flush counter=0, watchdog=0.
  - hold_timeout_o=0, int_req_o=0.
  - stall_o=0, flush_o=0, jump_en_o=0, jump_addr_o=0.
- Reset mid-operation:
  - Aborts FLUSH/INT_WAIT immediately; outputs go to reset values the same instant.
- Stall vector (combinational):
  - stall_o[k] = OR of hold_req_i[j] for j>=k.
- Bubble insertion:
  - flush_o[k+1] = stall_o[k] & ~stall_o[k+1], so the downstream stage gets a bubble while upstream is frozen.
- State IDLE:
  - jump_en_i=1: jump_en_o=1 and jump_addr_o=jump_addr_i in the same cycle (zero latency).
    - flush_o[NUM_STAGES-1:1] all 1; stall_o forced 0.
    - If FLUSH_CYCLES>1, load counter = FLUSH_CYCLES-1 and go to FLUSH; else stay in IDLE.
    - jump_en_i has priority over hold_req_i and irq_i.
  - Else irq_i=1 and hold_req_i==0: int_req_o=1 from the next cycle; go to INT_WAIT.
  - Else: jump_en_o=0, jump_addr_o=0; stall/bubble per the rules above.
- State FLUSH:
  - flush_o[NUM_STAGES-1:1]=1, stall_o=0, jump_en_o=0.
  - jump_en_i is ignored; younger instructions are flushed anyway.
  - Counter decrements each cycle; when it reaches 1, return to IDLE next cycle.
  - Flush is asserted for exactly FLUSH_CYCLES cycles in total, counting the redirect cycle.
- State INT_WAIT:
  - int_req_o=1; stall_o all 1; jump_en_i ignored.
  - int_ack_i=1 (same cycle):
    - jump_en_o=1, jump_addr_o=int_addr_i.
    - flush_o[NUM_STAGES-1:1]=1, stall_o=0; int_req_o drops the next cycle.
    - Go to FLUSH if FLUSH_CYCLES>1, else IDLE.
  - irq_i deasserting before ack does not cancel; the request is held until int_ack_i.
- Watchdog:
  - Counter increments each cycle with any hold_req_i bit set, saturating at 2^TO_WIDTH-1.
  - Any cycle with hold_req_i==0 resets it to 0.
  - On reaching the max, hold_timeout_o sets (registered, visible the next cycle) and stays set.
  - timeout_clr_i clears the flag; a simultaneous set wins.
  - The watchdog is frozen (no count) in INT_WAIT.
- Outputs stall_o/flush_o/jump_* are combinational from state and inputs.
- int_req_o and hold_timeout_o are registered.

Test Plan:
1. NUM_STAGES=3, hold_req_i=3'b010 for 3 cycles -> stall_o=3'b011 and flush_o=3'b100 each cycle; all 0 once released.
2. jump_en_i=1, jump_addr_i=32'h0000_0100, FLUSH_CYCLES=2 -> jump_en_o=1 with addr 0x100 the same cycle; flush_o=3'b110 for exactly 2 cycles; jump_en_o=0 in the second cycle.
3. jump_en_i=1 with hold_req_i=3'b001 and irq_i=1 in the same cycle -> jump wins (stall_o=0, int_req_o stays 0); interrupt taken after FLUSH completes.
4. irq_i=1 in IDLE with no hold -> int_req_o=1 next cycle and stall_o=3'b111; int_ack_i=1 with int_addr_i=32'h0000_0004 three cycles later -> jump_en_o=1 with addr 0x4 and flush_o=3'b110; int_req_o=0 the next cycle.
5. TO_WIDTH=3, hold_req_i held 7 cycles -> hold_timeout_o=1 from cycle 8; timeout_clr_i pulse clears it; a one-cycle hold drop before cycle 7 prevents the flag.
6. rst_n asserted during INT_WAIT and during FLUSH -> all outputs 0 immediately; after release, state is IDLE and a new jump behaves as in scenario 2.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the RISC-V core: per-stage stall/flush vectors, PC redirect
// on jump or interrupt entry, and a sticky watchdog on long pipeline holds.
module pipe_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_STAGES   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int TO_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  jump_en_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic [NUM_STAGES-1:0] hold_req_i,
    input  logic                  irq_i,
    input  logic                  int_ack_i,
    input  logic [ADDR_WIDTH-1:0] int_addr_i,
    input  logic                  timeout_clr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  jump_en_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  int_req_o,
    output logic                  hold_timeout_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        INT_WAIT = 2'd2
    } state_t;

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0]        FC_LOAD   = FCW'(FLUSH_CYCLES - 1);
    localparam logic [FCW-1:0]        FC_ONE    = FCW'(1);
    localparam logic [TO_WIDTH-1:0]   WD_MAX    = '1;
    localparam logic [NUM_STAGES-1:0] FLUSH_ALL = {{(NUM_STAGES-1){1'b1}}, 1'b0};

    state_t                  state_q, state_d;
    logic [FCW-1:0]          cnt_q, cnt_d;
    logic [TO_WIDTH-1:0]     wd_cnt;
    logic [NUM_STAGES-1:0]   stall_vec, bubble_vec;
    logic                    hold_any, wd_freeze, wd_set;

    assign state_o   = state_q;
    assign hold_any  = |hold_req_i;
    assign wd_freeze = (state_q == INT_WAIT);
    assign wd_set    = !wd_freeze && hold_any && (wd_cnt >= WD_MAX - 1'b1);

    // A hold request at stage k freezes every register upstream of it as well.
    always_comb begin
        logic acc;
        acc       = 1'b0;
        stall_vec = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            acc          = acc | hold_req_i[k];
            stall_vec[k] = acc;
        end
    end

    always_comb begin
        bubble_vec = '0;
        for (int k = 0; k < NUM_STAGES - 1; k++) begin
            bubble_vec[k+1] = stall_vec[k] & ~stall_vec[k+1];
        end
    end

    // Interrupt handshake: int_req_o is raised and held until the CSR unit answers with
    // int_ack_i; the acknowledged cycle redirects to int_addr_i and int_req_o drops after it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_o     = '0;
        flush_o     = '0;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        case (state_q)
            IDLE: begin
                if (jump_en_i) begin
                    jump_en_o   = 1'b1;
                    jump_addr_o = jump_addr_i;
                    flush_o     = FLUSH_ALL;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FC_LOAD;
                    end
                end else begin
                    stall_o = stall_vec;
                    flush_o = bubble_vec;
                    if (irq_i && !hold_any) state_d = INT_WAIT;
                end
            end
            FLUSH: begin
                flush_o = FLUSH_ALL;
                if (cnt_q <= FC_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            INT_WAIT: begin
                if (int_ack_i) begin
                    jump_en_o   = 1'b1;
                    jump_addr_o = int_addr_i;
                    flush_o     = FLUSH_ALL;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FC_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stall_o = '1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset forces the combinational outputs quiet regardless of the inputs.
        if (!rst_n) begin
            stall_o     = '0;
            flush_o     = '0;
            jump_en_o   = 1'b0;
            jump_addr_o = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            int_req_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_req_o <= (state_d == INT_WAIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt         <= '0;
            hold_timeout_o <= 1'b0;
        end else begin
            if (!wd_freeze) begin
                if (!hold_any)             wd_cnt <= '0;
                else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_set)             hold_timeout_o <= 1'b1;
            else if (timeout_clr_i) hold_timeout_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, each cycle compared
// against a behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int AW     = 32;
    localparam int NS     = 3;
    localparam int FC     = 2;
    localparam int TW     = 3;
    localparam int WD_MAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          jump_en_i = 1'b0;
    logic [AW-1:0] jump_addr_i = '0;
    logic [NS-1:0] hold_req_i = '0;
    logic          irq_i = 1'b0;
    logic          int_ack_i = 1'b0;
    logic [AW-1:0] int_addr_i = '0;
    logic          timeout_clr_i = 1'b0;
    logic [NS-1:0] stall_o, flush_o;
    logic          jump_en_o, int_req_o, hold_timeout_o;
    logic [AW-1:0] jump_addr_o;
    logic [1:0]    state_o;

    pipe_ctrl #(.ADDR_WIDTH(AW), .NUM_STAGES(NS), .FLUSH_CYCLES(FC), .TO_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_req_i(hold_req_i), .irq_i(irq_i), .int_ack_i(int_ack_i), .int_addr_i(int_addr_i),
        .timeout_clr_i(timeout_clr_i), .stall_o(stall_o), .flush_o(flush_o),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .int_req_o(int_req_o),
        .hold_timeout_o(hold_timeout_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL time_limit: run did not finish, act=timeout exp=finish");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: act=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_flush_left;   // flush-only cycles still owed after a redirect
    bit   m_int_wait;     // interrupt requested, waiting for acknowledge
    int   m_wd;           // consecutive counted hold cycles
    bit   m_to;           // sticky timeout flag

    task automatic model_reset();
        m_flush_left = 0;
        m_int_wait   = 1'b0;
        m_wd         = 0;
        m_to         = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic j, input logic [AW-1:0] ja, input logic [NS-1:0] h,
                         input logic irq, input logic ack, input logic [AW-1:0] ia,
                         input logic clr);
        logic [NS-1:0] e_stall, e_flush;
        logic          e_jump;
        logic [AW-1:0] e_addr;
        bit            frozen, hit;
        @(negedge clk);
        jump_en_i = j; jump_addr_i = ja; hold_req_i = h; irq_i = irq;
        int_ack_i = ack; int_addr_i = ia; timeout_clr_i = clr;
        #1;
        e_stall = '0; e_flush = '0; e_jump = 1'b0; e_addr = '0;
        frozen = m_int_wait;
        check("int_req", 32'(int_req_o), 32'(m_int_wait));
        check("timeout", 32'(hold_timeout_o), 32'(m_to));
        if (m_flush_left > 0) begin
            e_flush = 3'b110;
            m_flush_left--;
        end else if (m_int_wait) begin
            if (ack) begin
                e_jump = 1'b1; e_addr = ia; e_flush = 3'b110;
                m_int_wait = 1'b0;
                m_flush_left = FC - 1;
            end else begin
                e_stall = '1;
            end
        end else if (j) begin
            e_jump = 1'b1; e_addr = ja; e_flush = 3'b110;
            m_flush_left = FC - 1;
        end else begin
            for (int k = 0; k < NS; k++) e_stall[k] = ((h >> k) != '0);
            for (int k = 1; k < NS; k++) e_flush[k] = e_stall[k-1] && !e_stall[k];
            if (irq && h == '0) m_int_wait = 1'b1;
        end
        check("stall", 32'(stall_o), 32'(e_stall));
        check("flush", 32'(flush_o), 32'(e_flush));
        check("jump_en", 32'(jump_en_o), 32'(e_jump));
        check("jump_addr", jump_addr_o, e_addr);
        if (e_jump) exp_q.push_back(e_addr);
        if (jump_en_o) begin
            check("jump_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("jump_addr_q", jump_addr_o, exp_q.pop_front());
        end
        // watchdog: counts held cycles outside interrupt wait, flags on reaching max
        hit = 1'b0;
        if (!frozen) begin
            if (h != '0) begin
                if (m_wd < WD_MAX) m_wd++;
                if (m_wd == WD_MAX) hit = 1'b1;
            end else begin
                m_wd = 0;
            end
        end
        if (hit) m_to = 1'b1;
        else if (clr) m_to = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        jump_en_i = 1'b1; jump_addr_i = $urandom; hold_req_i = '1; irq_i = 1'b1;
        int_ack_i = 1'b1; int_addr_i = $urandom; timeout_clr_i = 1'b0;
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_jump_en", 32'(jump_en_o), 32'd0);
        check("rst_jump_addr", jump_addr_o, 32'd0);
        check("rst_int_req", 32'(int_req_o), 32'd0);
        check("rst_timeout", 32'(hold_timeout_o), 32'd0);
        repeat (n) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        jump_en_i = 1'b0; jump_addr_i = '0; hold_req_i = '0; irq_i = 1'b0;
        int_ack_i = 1'b0; int_addr_i = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        apply_reset(2);

        // hold on stage 1: upstream frozen, bubble into stage 2
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 3'b010, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // jump: same-cycle redirect, two flush cycles
        cycle(1'b1, 32'h0000_0100, '0, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // jump beats hold and irq; interrupt taken once the flush is over
        cycle(1'b1, 32'h0000_0200, 3'b001, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_0008, 1'b0);
        idle(3);

        // interrupt entry; irq drops before ack, request must persist
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h0000_0300, 3'b100, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 32'h0000_0004, 1'b0);
        idle(3);

        // watchdog: 7 held cycles set the flag; clear with hold continuing loses to set
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 3'b100, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 3'b100, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        idle(2);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 3'b001, 1'b0, 1'b0, '0, 1'b0);
        idle(1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 3'b011, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // reset during INT_WAIT, then during FLUSH; a jump afterwards behaves normally
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        apply_reset(1);
        cycle(1'b1, 32'h0000_0400, '0, 1'b0, 1'b0, '0, 1'b0);
        apply_reset(1);
        cycle(1'b1, 32'h0000_0100, '0, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [NS-1:0] h;
            h = ($urandom_range(0, 9) < ((i < 1000) ? 8 : 5)) ? NS'($urandom_range(1, 7)) : '0;
            cycle(($urandom_range(0, 9) == 0), $urandom, h, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 9) == 0));
            if (i % 500 == 499) apply_reset($urandom_range(1, 3));
        end
        idle(4);

        check("jump_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
